// File: rtl/m_lsu_ctrl_if.sv
// m_lsu_ctrl_if
//   Word-addressed data bus between the load/store sequencer and memory.
//   The master issues a request and holds every request field stable until
//   the slave returns a single-cycle bus_ack, which carries bus_rdata.
//
//   bus_req     master -> slave  request outstanding
//   bus_we      master -> slave  1 = write, 0 = read
//   bus_addr    master -> slave  word address, bits [1:0] always 0
//   bus_byteen  master -> slave  write byte enables (0 for reads)
//   bus_wdata   master -> slave  lane-aligned write data
//   bus_ack     slave -> master  completion, one cycle
//   bus_rdata   slave -> master  read word, valid with bus_ack
interface m_lsu_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/m_lsu_ctrl.sv
// m_lsu_ctrl
//   Memory-stage load/store sequencer. Accepts one load/store from the M
//   stage, runs it on the word-addressed data bus (variable-latency ack),
//   generates byte enables / lane-replicated store data, and lane-selects
//   and extends load data. Stalls F/D/E/M while a transaction is in flight
//   and reports misaligned accesses to CP0.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req_valid/we/op     M-stage request (op: 0 w, 1 bu, 2 b, 3 hu, 4 h)
//     req_addr/req_wdata  byte address, right-aligned store data
//     flush               CP0 exception/eret flush
//     stall               pipeline freeze
//     rdata/rdata_valid   extended load result, valid for one cycle
//     exc_adel/exc_ades   misaligned load / store (combinational)
//     bus_err             bus timeout pulse
//     bus                 m_lsu_ctrl_if.master data bus
//
//   Optional feature: define LSU_TIMEOUT_EN to abort a transaction after
//   TIMEOUT_CYCLES busy cycles without bus_ack (bus_err pulses, loads
//   return 0). Without it the sequencer waits for ack indefinitely.
module m_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  m_lsu_ctrl_if.master bus
);

  localparam logic [2:0] OP_BU = 3'd1;
  localparam logic [2:0] OP_BS = 3'd2;
  localparam logic [2:0] OP_HU = 3'd3;
  localparam logic [2:0] OP_HS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state, state_d;
  logic [1:0]  lane_p1;
  logic [2:0]  op_p1;
  logic        flush_pend_p1;
  logic        misaligned;
  logic        issue;
  logic        flush_go;
  logic        tmo_hit;

  // op values 5..7 fall through to word handling everywhere.
  function automatic logic f_is_byte(input logic [2:0] op);
    return (op == OP_BU) || (op == OP_BS);
  endfunction

  function automatic logic f_is_half(input logic [2:0] op);
    return (op == OP_HU) || (op == OP_HS);
  endfunction

  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] a);
    if (f_is_byte(op)) return 1'b0;
    if (f_is_half(op)) return a[0];
    return a != 2'b00;
  endfunction

  function automatic logic [3:0] f_byteen(input logic [2:0] op, input logic [1:0] a);
    if (f_is_byte(op)) return 4'b0001 << a;
    if (f_is_half(op)) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Replicating the datum into every lane lets memory pick it up with the
  // byte enables alone, independent of the address offset.
  function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] d);
    if (f_is_byte(op)) return {4{d[7:0]}};
    if (f_is_half(op)) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] op);
    logic [31:0]        sh_w;
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh_w = w >> {a, 3'b000};
    b    = sh_w[7:0];
    h    = a[1] ? w[31:16] : w[15:0];
    sb   = b;
    shw  = h;
    case (op)
      OP_BU:   return 32'(b);
      OP_BS:   return 32'(sb);
      OP_HU:   return 32'(h);
      OP_HS:   return 32'(shw);
      default: return w;
    endcase
  endfunction

  assign misaligned = f_misaligned(req_op, req_addr[1:0]);
  assign issue      = (state == S_IDLE) && req_valid && !misaligned && !flush;
  assign flush_go   = flush || flush_pend_p1;

`ifdef LSU_TIMEOUT_EN
  logic [9:0] tmo_cnt;
  logic       bus_err_q;
  assign tmo_hit = (state == S_BUSY) && !bus.bus_ack &&
                   (tmo_cnt == 10'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    exc_adel    = 1'b0;
    exc_ades    = 1'b0;
    case (state)
      S_IDLE: begin
        stall    = issue;
        exc_adel = req_valid && misaligned && !flush && !req_we;
        exc_ades = req_valid && misaligned && !flush && req_we;
        if (issue) state_d = S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        // A flushed transaction still completes on the bus, but its result
        // is dropped by skipping DONE.
        if (bus.bus_ack || tmo_hit) state_d = flush_go ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        rdata_valid = !bus.bus_we && !flush;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      bus.bus_req    <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_byteen <= '0;
      bus.bus_wdata  <= '0;
      lane_p1        <= '0;
      op_p1          <= '0;
      flush_pend_p1  <= 1'b0;
      rdata          <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt        <= '0;
      bus_err_q      <= 1'b0;
`endif
    end else begin
      state <= state_d;
`ifdef LSU_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state)
        // Issue: capture the request onto the bus.
        S_IDLE: begin
          if (issue) begin
            bus.bus_req    <= 1'b1;
            bus.bus_we     <= req_we;
            bus.bus_addr   <= {req_addr[31:2], 2'b00};
            bus.bus_byteen <= req_we ? f_byteen(req_op, req_addr[1:0]) : 4'b0000;
            bus.bus_wdata  <= f_wdata(req_op, req_wdata);
            lane_p1        <= req_addr[1:0];
            op_p1          <= req_op;
            flush_pend_p1  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
          end
        end
        // Busy: wait for ack, then register the extended load result.
        S_BUSY: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we && !flush_go) rdata <= f_extend(bus.bus_rdata, lane_p1, op_p1);
          end else if (tmo_hit) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we && !flush_go) rdata <= '0;
`ifdef LSU_TIMEOUT_EN
            bus_err_q   <= 1'b1;
`endif
          end else begin
            if (flush) flush_pend_p1 <= 1'b1;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 10'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
